// File: rtl/mem_walk_arb_if.sv
// Bundle of the requester, response, kill and memory-port signals of mem_walk_arb.
// Latency: none, wires only.
// Backpressure: valid/ready on every channel. slave = arbiter side, master = requesters + memory.
//
// Ports (arbiter view):
//   req_i_*      N requesters -> arbiter. Line numbers are packed, requester i at [i*MCN_W +: MCN_W].
//   resp_o_*     arbiter -> requesters. The data bus is shared; valid is one-hot or zero.
//   kill_i       per-requester flush.
//   mem_req_o_*  arbiter -> memory line request.
//   mem_resp_i_* memory -> arbiter line response.
interface mem_walk_arb_if #(
    parameter int N      = 4,
    parameter int MCN_W  = 58,
    parameter int DATA_W = 512
);
    logic [N-1:0]       req_i_valid;
    logic [N-1:0]       req_i_ready;
    logic [N*MCN_W-1:0] req_i_bits_mcn;
    logic [N-1:0]       resp_o_valid;
    logic [N-1:0]       resp_o_ready;
    logic [DATA_W-1:0]  resp_o_bits_data;
    logic [N-1:0]       kill_i;
    logic               mem_req_o_ready;
    logic               mem_req_o_valid;
    logic [MCN_W-1:0]   mem_req_o_bits_mcn;
    logic               mem_resp_i_ready;
    logic               mem_resp_i_valid;
    logic [DATA_W-1:0]  mem_resp_i_bits_data;

    modport slave (
        input  req_i_valid, req_i_bits_mcn, resp_o_ready, kill_i,
               mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data,
        output req_i_ready, resp_o_valid, resp_o_bits_data,
               mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready
    );

    modport master (
        output req_i_valid, req_i_bits_mcn, resp_o_ready, kill_i,
               mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data,
        input  req_i_ready, resp_o_valid, resp_o_bits_data,
               mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready
    );
endinterface

// File: rtl/mem_walk_arb.sv
// Round-robin arbiter of N VLB refill/walk requesters onto one memory line port, one transaction in flight.
// Latency: grant is combinational in IDLE, memory request 1 cycle later, response passed through with zero latency.
// Backpressure: mem_req valid is held until accepted; the response stalls on the winner's ready unless killed (then drained).
//
// Ports: clock, reset (async, active low), bus (mem_walk_arb_if.slave), busy_o (transaction in flight).
// Option: MEM_WALK_ARB_PRIO_EN gives requester 0 fixed top priority. Requesters 1..N-1 still round-robin.
module mem_walk_arb #(
    parameter int N      = 4,
    parameter int MCN_W  = 58,
    parameter int DATA_W = 512
) (
    input  logic              clock,
    input  logic              reset,
    mem_walk_arb_if.slave     bus,
    output logic              busy_o
);
    localparam int WW = $clog2(N);
    localparam logic [WW-1:0] LAST = WW'(N - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic [WW-1:0]      win_q, ptr_q, grant, idx;
    logic [MCN_W-1:0]   mcn_q;
    logic               kill_q;
    logic [N-1:0]       elig;
    logic               any_elig, found;
    logic               kill_now, kill_eff;
    logic [N-1:0]       req_rdy, rsp_vld;
    logic               mreq_vld, mrsp_rdy;
    logic [MCN_W-1:0]   mreq_mcn;
    logic [DATA_W-1:0]  rsp_dat;

    // Round-robin pick: walk from ptr_q+1 and wrap at N-1.
    always_comb begin
        elig     = bus.req_i_valid & ~bus.kill_i;
        any_elig = |elig;
        grant    = '0;
        found    = 1'b0;
        idx      = ptr_q;
        for (int k = 0; k < N; k++) begin
            idx = (idx == LAST) ? '0 : idx + WW'(1);
            if (!found && elig[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
`ifdef MEM_WALK_ARB_PRIO_EN
        if (elig[0]) begin
            grant = '0;
        end
`endif
    end

    // A kill of the winner takes effect in the same cycle. It also stays sticky in kill_q.
    assign kill_now = bus.kill_i[win_q];
    assign kill_eff = kill_q | kill_now;

    always_comb begin
        state_d  = state_q;
        req_rdy  = '0;
        rsp_vld  = '0;
        mreq_vld = 1'b0;
        mreq_mcn = '0;
        mrsp_rdy = 1'b0;
        rsp_dat  = '0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    req_rdy = {{(N-1){1'b0}}, 1'b1} << grant;
                    state_d = REQ;
                end
            end
            REQ: begin
                mreq_vld = 1'b1;
                mreq_mcn = mcn_q;
                if (bus.mem_req_o_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_dat = bus.mem_resp_i_bits_data;
                if (kill_eff) begin
                    mrsp_rdy = 1'b1;
                end else begin
                    mrsp_rdy = bus.resp_o_ready[win_q];
                    rsp_vld  = {N{bus.mem_resp_i_valid}} & ({{(N-1){1'b0}}, 1'b1} << win_q);
                end
                if (bus.mem_resp_i_valid && mrsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            mcn_q   <= '0;
            kill_q  <= 1'b0;
            ptr_q   <= LAST;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (any_elig) begin
                    win_q  <= grant;
                    mcn_q  <= bus.req_i_bits_mcn[int'(grant)*MCN_W +: MCN_W];
                    kill_q <= 1'b0;
                end
            end else if (kill_now) begin
                kill_q <= 1'b1;
            end
            if (state_q == RESP && bus.mem_resp_i_valid && mrsp_rdy) begin
`ifdef MEM_WALK_ARB_PRIO_EN
                // Requester 0 sits outside the rotation, so its completion leaves the pointer alone.
                if (win_q != '0) begin
                    ptr_q <= win_q;
                end
`else
                ptr_q <= win_q;
`endif
            end
        end
    end

    // The grant path is combinational from the requester valids. Gating it with reset keeps
    // every ready at 0 while reset is asserted.
    assign bus.req_i_ready        = req_rdy & {N{reset}};
    assign bus.resp_o_valid       = rsp_vld;
    assign bus.resp_o_bits_data   = rsp_dat;
    assign bus.mem_req_o_valid    = mreq_vld;
    assign bus.mem_req_o_bits_mcn = mreq_mcn;
    assign bus.mem_resp_i_ready   = mrsp_rdy;
    assign busy_o                 = (state_q != IDLE);
endmodule

// File: tb/tb_mem_walk_arb.sv
module tb_mem_walk_arb;
    localparam int N     = 4;
    localparam int MCN_W = 58;
    localparam int DW    = 512;

    logic clock;
    logic reset;
    logic busy_o;

    mem_walk_arb_if #(.N(N), .MCN_W(MCN_W), .DATA_W(DW)) bus();

    mem_walk_arb #(.N(N), .MCN_W(MCN_W), .DATA_W(DW)) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus),
        .busy_o (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus knobs, in percent.
    int p_req, p_kill, p_mem, p_rsp;

    // Requester agents.
    logic             rq_vld [N];
    logic [MCN_W-1:0] rq_mcn [N];

    // Memory model.
    logic             mem_pend, mem_vld;
    int               mem_cnt;
    logic [MCN_W-1:0] mem_mcn, acc_mcn;
    logic [DW-1:0]    mem_dat;

    // Handshakes seen on the last sample.
    logic [N-1:0] g_seen;
    logic         macc_seen, rhs_seen;

    // Transaction-level reference: 0 idle, 1 awaiting memory accept, 2 awaiting response.
    int               m_phase, m_ptr, m_win;
    logic [MCN_W-1:0] m_mcn;
    logic             m_killed;
    int               served [N];

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] t;
        t = 1;
        return t << i;
    endfunction

    function automatic logic [DW-1:0] line_of(input logic [MCN_W-1:0] mcn);
        logic [DW-1:0] d;
        for (int j = 0; j < DW / 64; j++) begin
            d[j*64 +: 64] = {6'h0, mcn} ^ (64'hA5A5A5A5A5A5A5A5 + 64'(j));
        end
        return d;
    endfunction

    // Next winner: first eligible requester after the previous one, modulo N.
    function automatic int pick(input logic [N-1:0] e, input int ptr);
`ifdef MEM_WALK_ARB_PRIO_EN
        if (e[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (bit_of(e, (ptr + k) % N)) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_i_valid[i] = rq_vld[i];
            bus.req_i_bits_mcn[i*MCN_W +: MCN_W] = rq_mcn[i];
        end
        bus.mem_resp_i_valid     = mem_vld;
        bus.mem_resp_i_bits_data = mem_dat;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (g_seen[i]) rq_vld[i] = 1'b0;
            if (!rq_vld[i] && ($urandom % 100) < p_req) begin
                rq_vld[i] = 1'b1;
                rq_mcn[i] = MCN_W'({$urandom, $urandom});
            end
            bus.kill_i[i]       = ($urandom % 100) < p_kill;
            bus.resp_o_ready[i] = ($urandom % 100) < p_rsp;
        end
        bus.mem_req_o_ready = ($urandom % 100) < p_mem;
        if (rhs_seen) begin
            mem_vld  = 1'b0;
            mem_pend = 1'b0;
        end
        if (macc_seen) begin
            mem_pend = 1'b1;
            mem_cnt  = $urandom % 4;
            mem_mcn  = acc_mcn;
        end
        if (mem_pend && !mem_vld) begin
            if (mem_cnt == 0) begin
                mem_vld = 1'b1;
                mem_dat = line_of(mem_mcn);
            end else begin
                mem_cnt--;
            end
        end
        g_seen    = '0;
        macc_seen = 1'b0;
        rhs_seen  = 1'b0;
        apply();
    endtask

    task automatic check_cycle();
        logic [N-1:0] e, exp_rdy, exp_rv;
        logic         ke, exp_mr;
        int           g;
        e = bus.req_i_valid & ~bus.kill_i;
        g = pick(e, m_ptr);
        chk("busy", DW'(busy_o), DW'(m_phase != 0));
        exp_rdy = (m_phase == 0 && g >= 0) ? onehot(g) : '0;
        chk("req_ready", DW'(bus.req_i_ready), DW'(exp_rdy));
        chk("mem_req_valid", DW'(bus.mem_req_o_valid), DW'(m_phase == 1));
        if (m_phase == 1) chk("mem_req_mcn", DW'(bus.mem_req_o_bits_mcn), DW'(m_mcn));
        if (m_phase == 2) begin
            ke     = m_killed | bit_of(bus.kill_i, m_win);
            exp_rv = (!ke && bus.mem_resp_i_valid) ? onehot(m_win) : '0;
            exp_mr = ke ? 1'b1 : bit_of(bus.resp_o_ready, m_win);
            chk("resp_valid", DW'(bus.resp_o_valid), DW'(exp_rv));
            chk("mem_resp_ready", DW'(bus.mem_resp_i_ready), DW'(exp_mr));
            if (exp_rv != '0) chk("resp_data", bus.resp_o_bits_data, line_of(m_mcn));
        end else begin
            chk("resp_valid_idle", DW'(bus.resp_o_valid), '0);
            chk("mem_resp_ready_idle", DW'(bus.mem_resp_i_ready), '0);
            chk("resp_data_idle", bus.resp_o_bits_data, '0);
        end
        // Handshakes as the DUT actually performed them drive the agents.
        g_seen    = bus.req_i_ready & bus.req_i_valid;
        macc_seen = bus.mem_req_o_valid & bus.mem_req_o_ready;
        acc_mcn   = bus.mem_req_o_bits_mcn;
        rhs_seen  = bus.mem_resp_i_valid & bus.mem_resp_i_ready;
        // Reference advances at the coming edge.
        case (m_phase)
            0: if (g >= 0) begin
                m_win    = g;
                m_mcn    = rq_mcn[g];
                m_killed = 1'b0;
                m_phase  = 1;
            end
            1: begin
                if (bit_of(bus.kill_i, m_win)) m_killed = 1'b1;
                if (bus.mem_req_o_ready) m_phase = 2;
            end
            default: begin
                ke = m_killed | bit_of(bus.kill_i, m_win);
                exp_mr = ke ? 1'b1 : bit_of(bus.resp_o_ready, m_win);
                if (bit_of(bus.kill_i, m_win)) m_killed = 1'b1;
                if (bus.mem_resp_i_valid && exp_mr) begin
                    m_phase = 0;
                    served[m_win]++;
`ifdef MEM_WALK_ARB_PRIO_EN
                    if (m_win != 0) m_ptr = m_win;
`else
                    m_ptr = m_win;
`endif
                end
            end
        endcase
    endtask

    task automatic step();
        drive();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req_ready"}, DW'(bus.req_i_ready), '0);
        chk({tag, "_mem_req_valid"}, DW'(bus.mem_req_o_valid), '0);
        chk({tag, "_resp_valid"}, DW'(bus.resp_o_valid), '0);
        chk({tag, "_mem_resp_ready"}, DW'(bus.mem_resp_i_ready), '0);
        chk({tag, "_busy"}, DW'(busy_o), '0);
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_ptr     = N - 1;
        m_killed  = 1'b0;
        mem_pend  = 1'b0;
        mem_vld   = 1'b0;
        mem_cnt   = 0;
        g_seen    = '0;
        macc_seen = 1'b0;
        rhs_seen  = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            rq_vld[i] = 1'b0;
            rq_mcn[i] = '0;
            served[i] = 0;
        end
        bus.kill_i          = '0;
        bus.resp_o_ready    = '0;
        bus.mem_req_o_ready = 1'b0;
        mem_dat             = '0;
        mem_mcn             = '0;
        acc_mcn             = '0;
        m_win               = 0;
        m_mcn               = '0;
        model_reset();
        apply();
        #1 reset = 1'b0;
        #2 check_quiet("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;

        // Single request from requester 0, memory stalls a few cycles.
        rq_vld[0] = 1'b1;
        rq_mcn[0] = MCN_W'(58'h123);
        p_req = 0; p_kill = 0; p_mem = 0; p_rsp = 100;
        run(4);
        p_mem = 100;
        run(10);

        // Saturated round-robin.
        p_req = 100; p_kill = 0; p_mem = 100; p_rsp = 100;
        run(80);

        // Heavy backpressure on both memory and response.
        p_req = 60; p_mem = 10; p_rsp = 20;
        run(300);

        // Frequent kills.
        p_req = 70; p_kill = 15; p_mem = 50; p_rsp = 60;
        run(400);

        // Mixed traffic.
        p_req = 40; p_kill = 4; p_mem = 60; p_rsp = 70;
        run(1500);

        // Reset while a response is awaited.
        p_req = 100; p_kill = 0; p_mem = 100; p_rsp = 0;
        guard = 0;
        while (m_phase != 2 && guard < 200) begin
            step();
            guard++;
        end
        chk("reach_resp", DW'(m_phase == 2), DW'(1));
        #2 reset = 1'b0;
        #1 check_quiet("mid_reset");
        model_reset();
        for (int i = 0; i < N; i++) rq_vld[i] = 1'b1;
        apply();
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        p_rsp = 100;
        run(100);

        for (int i = 0; i < N; i++) chk("served_any", DW'(served[i] > 0), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
